// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: default bus widths, response codes and the
// initiator state encoding. Also used by the SRAM responder and the arbiter.
package axi_lite_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Initiator state encoding; kept as plain constants so older tools and
    // external checkers can match on the raw 3-bit value.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RADDR = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_WRESP = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // Anything other than OKAY is reported as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: one request in, one AR/R or AW/W/B
// transaction out, one response beat back. Every output is a flop.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRB_W = DEF_STRB_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              req_ready_q, req_ready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Handshake valid/ready rule used on every channel: a transfer happens on
    // the rising edge where both valid and ready are high; a valid, once
    // raised, holds with a stable payload until that edge.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? ST_WRITE : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (arvalid_q && arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (rvalid && rready_q) begin
                    rsp_rdata_d = rdata;
                    rsp_err_d   = resp_is_err(rresp);
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, possibly on the same edge.
                aw_done_d = aw_done_q | (awvalid_q && awready);
                w_done_d  = w_done_q  | (wvalid_q  && wready);
                if (aw_done_d && w_done_d) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (bvalid && bready_q) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = resp_is_err(bresp);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Channel controls are decoded from the next state so they are
        // registered yet line up with the state they belong to.
        req_ready_d = (state_d == ST_IDLE);
        arvalid_d   = (state_d == ST_RADDR);
        rready_d    = (state_d == ST_RDATA);
        awvalid_d   = (state_d == ST_WRITE) && !aw_done_d;
        wvalid_d    = (state_d == ST_WRITE) && !w_done_d;
        bready_d    = (state_d == ST_WRESP);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign araddr    = addr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a cycle-stepped AXI-lite responder with
// programmable stalls, a word-array reference memory, table and random runs.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [7:0]  wstrb;
    logic [2:0]  dbg_state;

    axi_lite_master dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_state(dbg_state)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wstrb;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly, rsp_dly;
        logic        hold_req;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] resp_mem [8];
    logic [31:0] ref_mem [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [7:0] ws, input logic [1:0] resp,
                                input int ad, input int rd, input int awd, input int wdl,
                                input int bd, input int rspd, input logic hold,
                                input logic [31:0] er, input logic ee, input int el);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = ws; v.resp = resp;
        v.ar_dly = ad; v.r_dly = rd; v.aw_dly = awd; v.w_dly = wdl; v.b_dly = bd;
        v.rsp_dly = rspd; v.hold_req = hold;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic idle_inputs();
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; rsp_ready = 0;
    endtask

    // Issue one request and play the responder cycle by cycle, checking the
    // channel ordering rules each cycle.
    task automatic run_txn(input vec_t v, output logic [31:0] got_rdata, output logic got_err,
                           output int got_lat, output int rule_errs);
        logic ar_done, r_done, aw_done, w_done, b_done, seen, done;
        logic hs_ar, hs_r, hs_aw, hs_w, hs_b, hs_rsp;
        logic [31:0] cap_ar, cap_aw, cap_wd;
        logic [7:0] cap_ws;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, rsp_cnt, guard;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; seen = 0; done = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; rsp_cnt = 0; guard = 0;
        cap_ar = 0; cap_aw = 0; cap_wd = 0; cap_ws = 0;
        got_rdata = 'x; got_err = 'x; got_lat = -1; rule_errs = 0;
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(posedge aclk); #1; guard++;
        end
        if (req_ready !== 1'b1) begin
            fail_now("accept");
            req_valid = 0;
            return;
        end
        @(posedge aclk); #1;
        if (!v.hold_req) req_valid = 0;
        for (int c = 1; c <= 300; c++) begin
            if (req_ready !== 1'b0) rule_errs++;
            if (!v.we) begin
                if (arvalid !== ~ar_done) rule_errs++;
                if (arvalid === 1'b1 && araddr !== v.addr) rule_errs++;
                if (rready !== (ar_done & ~r_done)) rule_errs++;
                if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) rule_errs++;
                if (rsp_valid !== r_done) rule_errs++;
            end else begin
                if (awvalid !== ~aw_done) rule_errs++;
                if (wvalid !== ~w_done) rule_errs++;
                if (awvalid === 1'b1 && awaddr !== v.addr) rule_errs++;
                if (wvalid === 1'b1 && (wdata !== v.wdata || wstrb !== v.wstrb)) rule_errs++;
                if (bready !== (aw_done & w_done & ~b_done)) rule_errs++;
                if (arvalid !== 1'b0 || rready !== 1'b0) rule_errs++;
                if (rsp_valid !== b_done) rule_errs++;
            end
            if (rsp_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; got_lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
                end else if (rsp_rdata !== got_rdata || rsp_err !== got_err) begin
                    rule_errs++;
                end
            end
            arready = arvalid && (ar_cnt == v.ar_dly);
            if (arvalid) ar_cnt++;
            rvalid = rready && (r_cnt == v.r_dly);
            if (rready) r_cnt++;
            rdata = rvalid ? resp_mem[cap_ar[4:2]] : $urandom;
            rresp = rvalid ? v.resp : 2'($urandom);
            awready = awvalid && (aw_cnt == v.aw_dly);
            if (awvalid) aw_cnt++;
            wready = wvalid && (w_cnt == v.w_dly);
            if (wvalid) w_cnt++;
            bvalid = bready && (b_cnt == v.b_dly);
            if (bready) b_cnt++;
            bresp = bvalid ? v.resp : 2'($urandom);
            rsp_ready = rsp_valid && (rsp_cnt == v.rsp_dly);
            if (rsp_valid) rsp_cnt++;
            if (rsp_ready) req_valid = 0;
            hs_ar = arvalid & arready; hs_r = rvalid & rready;
            hs_aw = awvalid & awready; hs_w = wvalid & wready;
            hs_b = bvalid & bready; hs_rsp = rsp_valid & rsp_ready;
            if (hs_ar) cap_ar = araddr;
            if (hs_aw) cap_aw = awaddr;
            if (hs_w) begin cap_wd = wdata; cap_ws = wstrb; end
            @(posedge aclk); #1;
            if (hs_b && v.resp == RESP_OKAY)
                resp_mem[cap_aw[4:2]] = merge(resp_mem[cap_aw[4:2]], cap_wd, cap_ws[3:0]);
            ar_done |= hs_ar; r_done |= hs_r; aw_done |= hs_aw; w_done |= hs_w; b_done |= hs_b;
            if (hs_rsp) begin done = 1; break; end
        end
        idle_inputs();
        req_valid = 0;
        if (!done) begin
            fail_now("txn_done");
        end else if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            rule_errs++;
        end
    endtask

    // Reference behaviour: expected response from the word memory model.
    task automatic model(input vec_t v, output logic [31:0] er, output logic ee, output int el);
        int w;
        w = int'(v.addr[4:2]);
        ee = (v.resp != 2'b00);
        if (!v.we) begin
            er = ref_mem[w];
            el = 3 + v.ar_dly + v.r_dly;
        end else begin
            er = 32'h0;
            el = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
            if (!ee) ref_mem[w] = merge(ref_mem[w], v.wdata, v.wstrb[3:0]);
        end
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] g_rd, m_rd;
        logic g_err, m_err;
        int g_lat, m_lat, rules;
        vec_t v;

        areset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            resp_mem[i] = $urandom;
            ref_mem[i] = resp_mem[i];
        end
        resp_mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        resp_mem[1] = 32'hCAFEF00D; ref_mem[1] = 32'hCAFEF00D;

        repeat (3) @(posedge aclk);
        #1;
        check("reset_ctrl", {req_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err}, 0);
        check("reset_data", {rsp_rdata, araddr}, 0);
        check("reset_wpath", {awaddr, wdata, wstrb}, 0);
        check("reset_state", dbg_state, ST_IDLE);
        areset = 0;
        @(posedge aclk); #1;
        check("post_reset_req_ready", req_ready, 1);

        //       we addr          wdata         strb   resp  ar r aw w b rsp hold exp_rdata   err lat
        tbl[0] = mk(0, 32'h80000000, 32'h0,        8'h00, 2'b00, 0,0, 0,0,0, 0, 0, 32'hDEADBEEF, 0, 3);
        tbl[1] = mk(0, 32'h80000004, 32'h0,        8'h00, 2'b00, 4,3, 0,0,0, 0, 0, 32'hCAFEF00D, 0, 10);
        tbl[2] = mk(1, 32'h80000010, 32'h12345678, 8'h0F, 2'b00, 0,0, 2,0,0, 0, 0, 32'h0,        0, 5);
        tbl[3] = mk(0, 32'h80000010, 32'h0,        8'h00, 2'b00, 0,0, 0,0,0, 0, 0, 32'h12345678, 0, 3);
        tbl[4] = mk(0, 32'h80000000, 32'h0,        8'h00, 2'b10, 0,0, 0,0,0, 0, 0, 32'hDEADBEEF, 1, 3);
        tbl[5] = mk(1, 32'h80000004, 32'hAAAA5555, 8'hF3, 2'b11, 0,0, 0,0,1, 0, 0, 32'h0,        1, 4);
        tbl[6] = mk(0, 32'h80000004, 32'h0,        8'h00, 2'b00, 0,0, 0,0,0, 5, 1, 32'hCAFEF00D, 0, 3);
        tbl[7] = mk(1, 32'h8000001C, 32'h0,        8'h00, 2'b00, 0,0, 0,3,2, 0, 0, 32'h0,        0, 8);
        tbl[8] = mk(1, 32'h80000000, 32'h11223344, 8'h05, 2'b00, 0,0, 1,1,0, 1, 0, 32'h0,        0, 4);
        tbl[9] = mk(0, 32'h80000000, 32'h0,        8'h00, 2'b00, 1,0, 0,0,0, 0, 0, 32'hDE22BE44, 0, 4);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], g_rd, g_err, g_lat, rules);
            model(tbl[i], m_rd, m_err, m_lat);
            check($sformatf("tbl%0d_rdata", i), g_rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), g_err, tbl[i].exp_err);
            check($sformatf("tbl%0d_latency", i), g_lat, tbl[i].exp_lat);
            check($sformatf("tbl%0d_rules", i), rules, 0);
        end

        // Reset arriving while the write address is still stalled.
        req_valid = 1; req_we = 1; req_addr = 32'h80000008; req_wdata = 32'h0BADF00D; req_wstrb = 8'hFF;
        @(posedge aclk); #1;
        req_valid = 0;
        check("rstw_awvalid_before", awvalid, 1);
        @(posedge aclk); #1;
        areset = 1;
        @(posedge aclk); #1;
        check("rstw_ctrl_zero", {arvalid, awvalid, wvalid, rready, bready, rsp_valid, req_ready}, 0);
        check("rstw_state", dbg_state, ST_IDLE);
        areset = 0;
        @(posedge aclk); #1;
        check("rstw_req_ready", req_ready, 1);

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom_range(0, 1), 32'h80000000 + 32'($urandom_range(0, 7) * 4), $urandom,
                   8'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 32'h0, 1'b0, 0);
            model(v, m_rd, m_err, m_lat);
            run_txn(v, g_rd, g_err, g_lat, rules);
            check($sformatf("rnd%0d_rdata", i), g_rd, m_rd);
            check($sformatf("rnd%0d_err", i), g_err, m_err);
            check($sformatf("rnd%0d_latency", i), g_lat, m_lat);
            check($sformatf("rnd%0d_rules", i), rules, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
